// File: rtl/states_fill_responder_if.sv
// -----------------------------------------------------------------------------
// states_fill_responder_if
// Handshake and LED bus between a mode sequencer and one fill-hold-drain
// pattern engine.
//   enabler : mode-on qualifier (sequencer -> responder)
//   stBegin : level run request (sequencer -> responder)
//   dir     : fill/drain origin, 0 = bit 0, 1 = bit WIDTH-1 (sequencer -> responder)
//   out     : LED pattern (responder -> ledChooser)
//   stOver  : one-cycle completion pulse (responder -> sequencer)
//   busy    : high while the pattern is running (responder -> sequencer)
//   state   : debug state code (responder -> sequencer)
// -----------------------------------------------------------------------------
interface states_fill_responder_if #(
    parameter int WIDTH = 18
);
    logic             enabler;
    logic             stBegin;
    logic             dir;
    logic [WIDTH-1:0] out;
    logic             stOver;
    logic             busy;
    logic [2:0]       state;

    modport master (
        output enabler, stBegin, dir,
        input  out, stOver, busy, state
    );

    modport slave (
        input  enabler, stBegin, dir,
        output out, stOver, busy, state
    );
endinterface

// File: rtl/states_fill_responder.sv
// -----------------------------------------------------------------------------
// states_fill_responder
// Responder end of the stBegin/stOver handshake. While stBegin is held it
// lights the LED bus one step at a time (FILL), keeps it fully lit (HOLD),
// clears it one step at a time from the same end (DRAIN), then pulses stOver
// for one cycle (DONE) and returns to IDLE. A still-high stBegin re-arms it.
// Ports:
//   clk      : step clock
//   async_rs : asynchronous active-low reset
//   bus      : slave side of states_fill_responder_if (enabler, stBegin, dir
//              in; out, stOver, busy, state out). All outputs are registered.
// -----------------------------------------------------------------------------
module states_fill_responder #(
    parameter int WIDTH       = 18,
    parameter int HOLD_CYCLES = 4,
    parameter int STEP_DIV    = 1
) (
    input  logic                          clk,
    input  logic                          async_rs,
    states_fill_responder_if.slave        bus
);

    localparam int STEP_W = $clog2(WIDTH + 1);
    // Degenerate counters (STEP_DIV=1, HOLD_CYCLES=0) still get one bit.
    localparam int DIV_W  = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam int HOLD_W = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;

    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(WIDTH);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(STEP_DIV - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FILL  = 3'd1,
        ST_HOLD  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              dir_q, dir_d;
    logic [WIDTH-1:0]  out_q, out_d;
    logic              stover_q, stover_d;
    logic              busy_q, busy_d;

    logic              tick_s;
    logic [STEP_W-1:0] step_nx_s;

    // n LEDs lit, counted from bit 0 (d=0) or from bit WIDTH-1 (d=1).
    function automatic logic [WIDTH-1:0] fill_pat(input logic [STEP_W-1:0] n, input logic d);
        logic [WIDTH-1:0] p;
        p = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (d) begin
                p[i] = (i >= WIDTH - int'(n));
            end else begin
                p[i] = (i < int'(n));
            end
        end
        return p;
    endfunction

    // n LEDs cleared, counted from the same end the fill started.
    function automatic logic [WIDTH-1:0] drain_pat(input logic [STEP_W-1:0] n, input logic d);
        logic [WIDTH-1:0] p;
        p = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (d) begin
                p[i] = (i < WIDTH - int'(n));
            end else begin
                p[i] = (i >= int'(n));
            end
        end
        return p;
    endfunction

    assign tick_s    = (div_q == DIV_LAST);
    assign step_nx_s = step_q + STEP_W'(1);

    // Next-state, counter and output computation.
    always_comb begin
        state_d  = state_q;
        step_d   = step_q;
        div_d    = div_q;
        hold_d   = hold_q;
        dir_d    = dir_q;
        out_d    = out_q;
        stover_d = 1'b0;

        if (!bus.enabler) begin
            state_d = ST_IDLE;
            out_d   = '0;
            step_d  = '0;
            div_d   = '0;
            hold_d  = '0;
        end else if (!bus.stBegin &&
                     (state_q == ST_FILL || state_q == ST_HOLD || state_q == ST_DRAIN)) begin
            // Request withdrawn mid-run: abort silently, no completion pulse.
            state_d = ST_IDLE;
            out_d   = '0;
            step_d  = '0;
            div_d   = '0;
            hold_d  = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    out_d = '0;
                    if (bus.stBegin) begin
                        state_d = ST_FILL;
                        step_d  = '0;
                        div_d   = '0;
                        hold_d  = '0;
                        dir_d   = bus.dir;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_FILL: begin
                    if (tick_s) begin
                        div_d  = '0;
                        step_d = step_nx_s;
                        out_d  = fill_pat(step_nx_s, dir_q);
                        if (step_nx_s == STEP_LAST) begin
                            hold_d = '0;
                            if (HOLD_CYCLES == 0) begin
                                state_d = ST_DRAIN;
                                step_d  = '0;
                            end else begin
                                state_d = ST_HOLD;
                            end
                        end else begin
                            state_d = ST_FILL;
                        end
                    end else begin
                        div_d = div_q + DIV_W'(1);
                    end
                end
                ST_HOLD: begin
                    if (hold_q == HOLD_LAST) begin
                        state_d = ST_DRAIN;
                        step_d  = '0;
                        div_d   = '0;
                    end else begin
                        hold_d = hold_q + HOLD_W'(1);
                    end
                end
                ST_DRAIN: begin
                    if (tick_s) begin
                        div_d  = '0;
                        step_d = step_nx_s;
                        out_d  = drain_pat(step_nx_s, dir_q);
                        // Last LED cleared: completion pulse coincides with out=0.
                        if (step_nx_s == STEP_LAST) begin
                            state_d  = ST_DONE;
                            stover_d = 1'b1;
                        end else begin
                            state_d = ST_DRAIN;
                        end
                    end else begin
                        div_d = div_q + DIV_W'(1);
                    end
                end
                ST_DONE: begin
                    // Unconditional single cycle; stBegin is not looked at here.
                    state_d = ST_IDLE;
                    out_d   = '0;
                end
                default: begin
                    state_d = ST_IDLE;
                    out_d   = '0;
                    step_d  = '0;
                    div_d   = '0;
                    hold_d  = '0;
                end
            endcase
        end

        busy_d = (state_d == ST_FILL) || (state_d == ST_HOLD) || (state_d == ST_DRAIN);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge async_rs) begin
        if (!async_rs) begin
            state_q  <= ST_IDLE;
            step_q   <= '0;
            div_q    <= '0;
            hold_q   <= '0;
            dir_q    <= 1'b0;
            out_q    <= '0;
            stover_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            step_q   <= step_d;
            div_q    <= div_d;
            hold_q   <= hold_d;
            dir_q    <= dir_d;
            out_q    <= out_d;
            stover_q <= stover_d;
            busy_q   <= busy_d;
        end
    end

    assign bus.out    = out_q;
    assign bus.stOver = stover_q;
    assign bus.busy   = busy_q;
    assign bus.state  = state_q;

endmodule
